lb_byte_bridge: RTL
===================

Name: lb_byte_bridge

Overview:
- Upstream command/response stage for the localbus register map: packs a byte stream (UART or UDP payload) into one `{ctrl,addr,data}` command word.
- Presents that word on `wcmd`/`wvalid`, waits for the regmap's `rcmd`/`rready` echo, then serialises the echo back out as bytes.
- Sits between the byte transport and the regmap. Exactly one command is in flight at a time.

Parameters:
- LBCWIDTH, 8, ctrl field width.
- LBAWIDTH, 24, address field width.
- LBDWIDTH, 32, data field width.
- IDLE_TIMEOUT, 1000000, clk cycles allowed between bytes of a partial frame before it is discarded.
- RESP_TIMEOUT, 255, clk cycles to wait for `rready` after `wvalid`.
- Derived localparams:
  - LBWIDTH = LBCWIDTH+LBAWIDTH+LBDWIDTH. Elaboration error if not a multiple of 8.
  - NBYTES = LBWIDTH/8.

Ports:
- clk, in, 1: single clock, also drives the regmap `lb.clk`.
- rst_n, in, 1: asynchronous assert, active-low reset.
- in_byte, in, 8: received byte.
- in_valid, in, 1: `in_byte` valid.
- in_ready, out, 1: bridge accepts `in_byte`.
- out_byte, out, 8: response byte.
- out_valid, out, 1: `out_byte` valid.
- out_ready, in, 1: downstream accepts `out_byte`.
- wcmd, out, LBWIDTH: command word to the regmap.
- wvalid, out, 1: one-cycle command strobe.
- rcmd, in, LBWIDTH: echoed/read-back word from the regmap.
- rready, in, 1: `rcmd` valid strobe.
- frame_drop, out, 1: one-cycle pulse when a partial frame is dropped on idle timeout.
- resp_timeout, out, 1: one-cycle pulse when `rready` does not arrive in time.
- busy, out, 1: high in any state other than RX.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=RX, byte counter=0, shift regs=0.
  - All outputs 0 except `in_ready`=1.
  - A reset asserted mid-frame or mid-TX discards all state. No partial output follows release.
- Byte order: big-endian. The first byte received is `wcmd[LBWIDTH-1:LBWIDTH-8]` (ctrl MSB). The first byte sent is `rcmd[LBWIDTH-1:LBWIDTH-8]`.
- RX state:
  - `in_ready`=1.
  - On `in_valid&in_ready`: shift the byte into the assembly register, cnt++, clear the idle counter.
  - On the NBYTES-th byte: load `wcmd` and go to ISSUE on the next cycle.
  - Idle counter runs only while 0<cnt<NBYTES. When it reaches IDLE_TIMEOUT: cnt←0, pulse `frame_drop`, stay in RX.
  - If a byte arrives on the same cycle as the timeout, the timeout wins and the byte is dropped.
- ISSUE state:
  - `wvalid`=1 for exactly one cycle, `in_ready`=0.
  - `wcmd` is held stable from ISSUE until the next frame completes.
  - Next state WAIT, response counter cleared.
- WAIT state:
  - `in_ready`=0. The response counter increments each cycle.
  - On `rready`: capture `rcmd` into the TX shift register, go to TX. Nominal regmap latency is 3 cycles after `wvalid`.
  - If the counter reaches RESP_TIMEOUT without `rready`: pulse `resp_timeout`, go to RX, send no bytes.
  - If `rready` occurs on the timeout cycle, the capture wins and no timeout pulse is issued.
- TX state:
  - `out_valid`=1, `out_byte` = top byte of the shift register.
  - On `out_valid&out_ready`: shift left 8, txcnt++.
  - After the NBYTES-th handshake: `out_valid`=0 on the next cycle, go to RX.
  - `out_byte` stays stable while `out_valid&!out_ready`.
  - `in_ready`=0 throughout TX: bytes arriving during TX are back-pressured, not lost.
- `rready` outside WAIT is ignored. It must not corrupt TX data.
- Latency:
  - Last input byte handshake to `wvalid`: 1 cycle.
  - `rready` to first `out_valid`: 1 cycle.
- `busy` = (state!=RX). `frame_drop`/`resp_timeout` are registered single-cycle pulses.

Decomposition:
- Shared package `lb_pkg`:
  - LBCWIDTH/LBAWIDTH/LBDWIDTH defaults and derived LBWIDTH, NBYTES.
  - Command codes WRITECMD=1, READCMD=0.
  - enum `lb_bridge_state_t` {RX, ISSUE, WAIT, TX}.
- One sub-module `lb_byte_ser`: a parameterised NBYTES-wide parallel-load, MSB-first byte serialiser with valid/ready, used for the TX path. The RX packing stays inline.

Test Plan:
- Write, no backpressure:
  - Stimulus: bytes 01 00 00 10 DE AD BE EF; regmap model echoes after 3 cycles.
  - Required: one `wvalid` with `wcmd`=64'h01000010_DEADBEEF; out bytes 01 00 00 10 DE AD BE EF in order.
- Read:
  - Stimulus: bytes 00 00 00 20 00 00 00 00; model returns `rcmd`=64'h00000020_12345678.
  - Required: out bytes 00 00 00 20 12 34 56 78.
- Output backpressure:
  - Stimulus: write frame with `out_ready` toggled 1,0,0,1,…
  - Required: `out_byte` held during stalls; all 8 bytes delivered exactly once.
  - Also: `in_valid` held high during TX sees `in_ready`=0 until TX ends, then the next frame is assembled correctly.
- Idle timeout (IDLE_TIMEOUT=16):
  - Stimulus: 3 bytes, then a 20-cycle gap, then a full 8-byte frame.
  - Required: one `frame_drop` pulse; `wcmd` equals the later frame only.
- Response timeout (RESP_TIMEOUT=8):
  - Stimulus: full frame, model never asserts `rready`.
  - Required: `resp_timeout` pulse 8 cycles after `wvalid`; `out_valid` never asserted; `busy` falls.
  - Also: a late `rready` afterwards is ignored.
- Reset mid-TX:
  - Stimulus: deassert `rst_n` after the 4th output byte.
  - Required: all outputs at reset values immediately; after release, no stale bytes; a new frame works normally.

Source files
------------

// File: rtl/lb_pkg.sv
// Shared localbus definitions: default field widths, command codes and the
// byte-bridge state encoding.
package lb_pkg;

  localparam int LBCWIDTH_DFLT = 8;
  localparam int LBAWIDTH_DFLT = 24;
  localparam int LBDWIDTH_DFLT = 32;
  localparam int LBWIDTH_DFLT  = LBCWIDTH_DFLT + LBAWIDTH_DFLT + LBDWIDTH_DFLT;
  localparam int NBYTES_DFLT   = LBWIDTH_DFLT / 8;

  localparam logic [7:0] WRITECMD = 8'd1;
  localparam logic [7:0] READCMD  = 8'd0;

  typedef enum logic [1:0] {RX, ISSUE, WAIT, TX} lb_bridge_state_t;

endpackage

// File: rtl/lb_byte_ser.sv
// Parallel-load, MSB-first byte serialiser with valid/ready handshake.
// done pulses combinationally on the handshake of the last byte.
module lb_byte_ser #(
  parameter int NBYTES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [NBYTES*8-1:0]   load_data,
  output logic [7:0]            out_byte,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  done
);

  localparam int CW = $clog2(NBYTES + 1);

  logic [NBYTES*8-1:0] sh_q;
  logic [CW-1:0]       cnt_q;
  logic                hs;

  assign out_byte = sh_q[NBYTES*8-1 -: 8];
  assign hs       = out_valid && out_ready;
  assign done     = hs && (cnt_q == CW'(NBYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q      <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      sh_q      <= load_data;
      cnt_q     <= '0;
      out_valid <= 1'b1;
    end else if (hs) begin
      sh_q <= sh_q << 8;
      if (done) begin
        cnt_q     <= '0;
        out_valid <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lb_byte_bridge.sv
// Byte-stream to localbus command bridge: packs NBYTES bytes into one command,
// strobes it to the regmap, then serialises the echoed word back out.
//
// state | meaning
// RX    | assembling a frame, in_ready high, idle timer guards partial frames
// ISSUE | one-cycle wvalid strobe of the assembled command
// WAIT  | waiting for rready, response timer running
// TX    | serialising the captured rcmd MSB-first
module lb_byte_bridge
  import lb_pkg::*;
#(
  parameter int LBCWIDTH     = LBCWIDTH_DFLT,
  parameter int LBAWIDTH     = LBAWIDTH_DFLT,
  parameter int LBDWIDTH     = LBDWIDTH_DFLT,
  parameter int IDLE_TIMEOUT = 1000000,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [7:0]                             in_byte,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [7:0]                             out_byte,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [LBCWIDTH+LBAWIDTH+LBDWIDTH-1:0]  wcmd,
  output logic                                   wvalid,
  input  logic [LBCWIDTH+LBAWIDTH+LBDWIDTH-1:0]  rcmd,
  input  logic                                   rready,
  output logic                                   frame_drop,
  output logic                                   resp_timeout,
  output logic                                   busy
);

  localparam int LBWIDTH = LBCWIDTH + LBAWIDTH + LBDWIDTH;
  localparam int NBYTES  = LBWIDTH / 8;
  localparam int CW      = $clog2(NBYTES + 1);
  localparam int IW      = $clog2(IDLE_TIMEOUT + 1);
  localparam int RW      = $clog2(RESP_TIMEOUT + 1);

  if ((LBWIDTH % 8) != 0 || NBYTES < 2) begin : g_bad_width
    $error("lb_byte_bridge: LBWIDTH must be a multiple of 8 and at least 16");
  end
  if (RESP_TIMEOUT < 2 || IDLE_TIMEOUT < 1) begin : g_bad_timeout
    $error("lb_byte_bridge: RESP_TIMEOUT must be >= 2 and IDLE_TIMEOUT >= 1");
  end

  lb_bridge_state_t state, state_nxt;

  logic [LBWIDTH-9:0] asm_q;
  logic [CW-1:0]      cnt_q;
  logic [IW-1:0]      idle_q;
  logic [RW-1:0]      rsp_q;
  logic               in_hs;
  logic               idle_tmo;
  logic               frame_done;
  logic               rsp_hit;
  logic               rsp_tmo;
  logic               ser_done;

  assign in_ready   = (state == RX);
  assign wvalid     = (state == ISSUE);
  assign busy       = (state != RX);
  assign in_hs      = in_valid && in_ready;
  // A byte landing on the timeout edge is discarded along with the partial frame.
  assign idle_tmo   = (state == RX) && (cnt_q != '0) && (idle_q == '0);
  assign frame_done = in_hs && !idle_tmo && (cnt_q == CW'(NBYTES - 1));
  assign rsp_hit    = (state == WAIT) && rready;
  assign rsp_tmo    = (state == WAIT) && !rready && (rsp_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX:      if (frame_done) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (rsp_hit) state_nxt = TX;
               else if (rsp_tmo) state_nxt = RX;
      TX:      if (ser_done) state_nxt = RX;
      default: state_nxt = RX;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q        <= '0;
      cnt_q        <= '0;
      idle_q       <= '0;
      rsp_q        <= '0;
      wcmd         <= '0;
      frame_drop   <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      frame_drop   <= idle_tmo;
      resp_timeout <= rsp_tmo;
      if (state == RX) begin
        if (idle_tmo) begin
          cnt_q <= '0;
        end else if (in_hs) begin
          asm_q  <= (asm_q << 8) | (LBWIDTH-8)'(in_byte);
          idle_q <= IW'(IDLE_TIMEOUT - 1);
          if (frame_done) begin
            wcmd  <= {asm_q, in_byte};
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else if (cnt_q != '0) begin
          idle_q <= idle_q - 1'b1;
        end
      end
      // Loaded so the timeout pulse lands RESP_TIMEOUT cycles after wvalid.
      if (state == ISSUE) begin
        rsp_q <= RW'(RESP_TIMEOUT - 2);
      end else if (state == WAIT && rsp_q != '0) begin
        rsp_q <= rsp_q - 1'b1;
      end
    end
  end

  lb_byte_ser #(.NBYTES(NBYTES)) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (rsp_hit),
    .load_data (rcmd),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (ser_done)
  );

endmodule
